// File: rtl/uart_rx.sv
// 8N1 console UART receiver with 16x oversampling and a KL8-style held flag/data interface.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around the bit centre.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int MID        = OVERSAMPLE / 2 - 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_baud_clk,
  input  logic       rxd,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = MID + 2;
`else
  localparam int DEC = MID;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state, state_nxt;
  logic          baud_p0, tick;
  logic          rxd_p0, rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          sample, decide, wrap, complete;

  // Baud edge detect and line synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_p0 <= 1'b0;
      tick    <= 1'b0;
      rxd_p0  <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      baud_p0 <= rx_baud_clk;
      tick    <= rx_baud_clk & ~baud_p0;
      rxd_p0  <= rxd;
      rxd_s   <= rxd_p0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_MID1 = CW'(MID + 1);
  logic smp_mid, smp_mid1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_mid  <= 1'b1;
      smp_mid1 <= 1'b1;
    end else if (tick) begin
      if (cnt == CNT_MID)  smp_mid  <= rxd_s;
      if (cnt == CNT_MID1) smp_mid1 <= rxd_s;
    end
  end

  assign sample = (smp_mid & smp_mid1) | (smp_mid & rxd_s) | (smp_mid1 & rxd_s);
`else
  assign sample = rxd_s;
`endif

  assign decide   = tick && (cnt == CNT_DEC);
  assign wrap     = tick && (cnt == CNT_LAST);
  assign complete = decide && (state == S_STOP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick && !rxd_s) state_nxt = S_START;
      S_START: if (decide && sample) state_nxt = S_IDLE;
               else if (wrap)        state_nxt = S_DATA;
      S_DATA:  if (wrap && bitn == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (decide) state_nxt = sample ? S_IDLE : S_BREAK;
      S_BREAK: if (tick && rxd_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != S_IDLE);
  end

  // Bit timing counters and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
    end else if (tick) begin
      case (state)
        S_START: begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (wrap) bitn <= '0;
        end
        S_DATA: begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (decide) sh <= {sample, sh[7:1]};
          if (wrap && bitn != 3'd7) bitn <= bitn + 3'd1;
        end
        S_STOP:  cnt <= wrap ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // CPU-side flags: a completion outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (complete) begin
      rx_data     <= sh;
      rx_ready    <= 1'b1;
      framing_err <= ~sample;
      overrun_err <= rx_ready & ~rx_clear;
    end else if (rx_clear) begin
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule
